// File: rtl/uart_tx_fifo_controller_pkg.sv
// Shared constants for the UART TX FIFO controller: default widths and the
// drain FSM state encoding.
package uart_tx_fifo_controller_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;
  localparam int ADDR_WIDTH_DEF = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
endpackage

// File: rtl/uart_tx_fifo_controller_sync_fifo.sv
// Synchronous FIFO with occupancy count and a registered read port; full is
// judged before a same-cycle pop, so a push into a full FIFO is always dropped.
module uart_tx_fifo_controller_sync_fifo
  import uart_tx_fifo_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  full,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_ok, rd_ok;

  assign full  = (usedw == (ADDR_WIDTH+1)'(DEPTH));
  assign empty = (usedw == '0);
  assign wr_ok = push & ~full;
  assign rd_ok = pop & ~empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
      rdata  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        rdata  <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   usedw <= usedw + (ADDR_WIDTH+1)'(1);
        2'b01:   usedw <= usedw - (ADDR_WIDTH+1)'(1);
        default: usedw <= usedw;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo_controller.sv
// UART TX FIFO controller: write edge detect into a FIFO, drained one byte at a
// time into the serializer through a tx_start / tx_busy handshake.
module uart_tx_fifo_controller
  import uart_tx_fifo_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  overflow,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  idle
);
  logic       write_d;
  logic       push, pop;
  logic [1:0] state;

  assign push = write & ~write_d;
  assign pop  = (state == ST_IDLE) & ~empty & ~tx_busy;
  assign idle = (state == ST_IDLE) & empty;

  uart_tx_fifo_controller_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (data),
    .pop   (pop),
    .rdata (tx_data),
    .usedw (usedw),
    .full  (full),
    .empty (empty)
  );

  // write_d resets high so a write held across reset release is not a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_d  <= 1'b1;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      write_d  <= write;
      tx_start <= 1'b0;
      if (push & full) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_start <= 1'b1;
            state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: if (tx_busy)  state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!tx_busy) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_controller.sv
// Bench for uart_tx_fifo_controller: cycle table for reset/latency/handshake,
// directed corner sequences, then random traffic against a queue-based model.
module tb_uart_tx_fifo_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       full, empty, overflow, tx_start, idle;
  logic [4:0] usedw;
  logic [7:0] tx_data;

  uart_tx_fifo_controller dut (
    .clk(clk), .rst(rst), .write(write), .data(data), .full(full), .empty(empty),
    .usedw(usedw), .overflow(overflow), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, wr;
    logic [7:0] d;
    logic       busy;
    logic       st;
    logic [7:0] td;
    logic [4:0] uw;
    logic       em, fu, ov, id;
  } vec_t;

  vec_t       tbl [14];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] q [$];
  logic [7:0] sent [$];
  bit         ovf_m = 1'b0;
  bit         wr_prev_m = 1'b1;
  bit         model_on = 1'b0;
  bit         auto_tx = 1'b0;
  bit         force_busy = 1'b0;
  bit         prev_start = 1'b0;
  int         busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the reference model: the push decision uses the model's
  // occupancy before the edge; every tx_start retires the oldest queued byte.
  task automatic tick();
    if (rst) begin
      q.delete();
      ovf_m = 1'b0;
    end else if (write && !wr_prev_m) begin
      if (q.size() == 16) ovf_m = 1'b1;
      else q.push_back(data);
    end
    wr_prev_m = rst ? 1'b1 : write;
    @(posedge clk); #1;
    if (tx_start) begin
      sent.push_back(tx_data);
      if (model_on) begin
        check("start_width", {31'd0, prev_start}, 32'd0);
        if (q.size() == 0) check("spurious_start", 32'd1, 32'd0);
        else check("tx_order", {24'd0, tx_data}, {24'd0, q.pop_front()});
      end
    end
    prev_start = tx_start;
    if (model_on) begin
      check("usedw", {27'd0, usedw}, q.size());
      check("flags", {29'd0, full, empty, overflow},
            {29'd0, q.size() == 16, q.size() == 0, ovf_m});
    end
    if (tx_start && auto_tx) busy_cnt = $urandom_range(1, 4);
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = force_busy || (busy_cnt > 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    write = 1'b0;
    force_busy = 1'b0;
    auto_tx = 1'b1;
    while (!(idle && busy_cnt == 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", {31'd0, idle && busy_cnt == 0}, 32'd1);
  endtask

  task automatic pulse(input logic [7:0] b);
    write = 1'b1; data = b; tick();
    write = 1'b0; tick();
  endtask

  initial begin
    int         peak, base;
    logic [7:0] exp_b;

    //           rst   wr    data   busy  | st    td     uw    em    fu    ov    id
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; write = tbl[i].wr; data = tbl[i].d; tx_busy = tbl[i].busy;
      @(posedge clk); #1;
      check($sformatf("row%0d", i),
            {14'd0, tx_start, tx_data, usedw, empty, full, overflow, idle},
            {14'd0, tbl[i].st, tbl[i].td, tbl[i].uw, tbl[i].em, tbl[i].fu, tbl[i].ov, tbl[i].id});
    end
    write = 1'b0; tx_busy = 1'b0; wr_prev_m = 1'b0; model_on = 1'b1;

    // write held five cycles: a single push and a single frame
    auto_tx = 1'b1; base = sent.size(); peak = 0;
    write = 1'b1; data = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (int'(usedw) > peak) peak = int'(usedw);
    end
    drain(100);
    check("hold_peak", peak, 1);
    check("hold_frames", sent.size() - base, 1);
    if (sent.size() > base) check("hold_byte", {24'd0, sent[base]}, 32'h3C);

    // fill while blocked, overflow on the 17th byte, then ordered drain
    force_busy = 1'b1; tx_busy = 1'b1; base = sent.size();
    for (int i = 0; i < 17; i++) begin
      pulse(8'(i));
      if (i == 15) check("full_at_16", {31'd0, full}, 32'd1);
    end
    check("ovf_17th", {31'd0, overflow}, 32'd1);
    drain(300);
    check("fill_frames", sent.size() - base, 16);
    for (int i = 0; i < 16 && base + i < sent.size(); i++)
      check("fill_order", {24'd0, sent[base+i]}, i);

    // pushes interleaved with draining, across pointer wrap
    base = sent.size();
    for (int i = 0; i < 20; i++) pulse(8'($urandom));
    drain(300);
    check("wrap_frames", sent.size() - base, 20);

    // reset while a frame is in WAIT_DONE with three bytes still queued
    auto_tx = 1'b0; force_busy = 1'b1; tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) pulse(8'h80 + 8'(i));
    force_busy = 1'b0; tx_busy = 1'b0;
    tick();
    check("rst_pre_pop", {31'd0, prev_start}, 32'd1);
    force_busy = 1'b1; tx_busy = 1'b1;
    tick(); tick();
    check("rst_queued", {27'd0, usedw}, 32'd3);
    rst = 1'b1; tick();
    check("rst_state", {27'd0, tx_start, usedw, empty, overflow, idle},
          {27'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1});
    rst = 1'b0; force_busy = 1'b0; tx_busy = 1'b0; base = sent.size();
    for (int i = 0; i < 10; i++) tick();
    check("rst_no_start", sent.size() - base, 0);

    // write high across reset release does not push; a fresh rise does
    force_busy = 1'b1; tx_busy = 1'b1;
    write = 1'b1; data = 8'h11; rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("held_no_push", {27'd0, usedw}, 32'd0);
    write = 1'b0; tick();
    write = 1'b1; data = 8'hC7; tick(); tick(); tick();
    check("rise_one_push", {27'd0, usedw}, 32'd1);
    drain(100);
    exp_b = 8'hC7;
    check("rise_byte", {24'd0, sent[sent.size()-1]}, {24'd0, exp_b});

    // random traffic, random frame lengths, blocking periods and rare resets
    auto_tx = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      write = $urandom_range(0, 1);
      data = 8'($urandom);
      if ($urandom_range(0, 49) == 0) force_busy = ~force_busy;
      tick();
    end
    rst = 1'b0;
    drain(500);
    check("rand_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_controller.md
Name: uart_tx_fifo_controller

Overview:
- Transmit-side counterpart of the UART receive FIFO controller.
- Accepts bytes from the system side through a level-to-pulse write strobe and buffers them in an internal synchronous FIFO.
- Drains the FIFO one byte at a time into the UART transmitter using a tx_start/tx_busy handshake.
- Sits between the command/packet logic and the UART TX serializer.

Parameters:
DATA_WIDTH, 8, byte width of FIFO entries and tx_data
DEPTH, 16, FIFO entries; must be a power of two
ADDR_WIDTH, 4, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
write  input  1  system write request, level; each rising edge pushes one byte
data  input  DATA_WIDTH  byte to push; sampled on the edge where write is first seen high
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
usedw  output  ADDR_WIDTH+1  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky; set when a push is dropped because the FIFO is full
tx_busy  input  1  UART transmitter is shifting a frame
tx_start  output  1  one-cycle pulse: transmitter loads tx_data
tx_data  output  DATA_WIDTH  byte presented to the transmitter
idle  output  1  FSM in IDLE and FIFO empty; all data sent

Behaviour:
- Reset (rst=1 at a clock edge) produces the following values:
  - tx_start=0, tx_data=0, usedw=0, empty=1, full=0, overflow=0, idle=1.
  - Pointers are cleared and the FSM goes to IDLE.
  - write_d is set to 1, so a write held high across reset release does not push.
- Reset mid-operation discards all queued bytes and any frame handshake in progress.
- Write edge detect:
  - write_d registers write.
  - push = write & ~write_d.
  - A write held high for N cycles gives exactly one push.
- Push:
  - If push and not full, mem[wr_ptr] <= data, wr_ptr increments with modulo-DEPTH wrap, and usedw increments.
  - If push and full, the byte is dropped, overflow is set, and the pointers are unchanged.
- Pop:
  - Performed only by the FSM in IDLE.
  - tx_data <= mem[rd_ptr], rd_ptr increments with wrap, and usedw decrements.
- Simultaneous push and pop in the same cycle leaves usedw unchanged and lets both pointers advance.
- A push into a full FIFO is dropped even if a pop occurs in the same cycle; full is evaluated before the pop.
- full = (usedw==DEPTH); empty = (usedw==0). Both are derived from registered usedw.
- FSM states:
  - IDLE:
    - If !empty and !tx_busy, pop, set tx_start<=1 and go to WAIT_BUSY.
    - Otherwise stay in IDLE.
  - WAIT_BUSY:
    - tx_start<=0.
    - If tx_busy=1, go to WAIT_DONE; otherwise stay.
  - WAIT_DONE:
    - If tx_busy=0, go to IDLE; otherwise stay.
- tx_start is high for exactly one cycle, coincident with the new tx_data value.
- tx_data holds stable until the next pop.
- Latency: write first sampled high at edge N → byte pushed at edge N → tx_start=1 in the cycle following edge N+1 (2 edges from write to start when idle).
- Back-to-back bytes: the next tx_start occurs no earlier than 1 cycle after the edge where tx_busy is seen low in WAIT_DONE, i.e. 2 cycles after tx_busy falls.
- tx_busy high while in IDLE blocks pops; the FSM waits.
- idle = (state==IDLE) & empty.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2) and the default DATA_WIDTH and DEPTH constants.
- One natural sub-module: sync_fifo, holding memory, pointers, usedw, full and empty with a single-cycle registered read.
- The top level holds the edge detect, overflow flag and drain FSM.

Test Plan:
- Reset then write pulse with data=8'hA5, tx_busy model responding 1 cycle after tx_start for 10 cycles:
  - tx_start high exactly one cycle, 2 edges after write, with tx_data=8'hA5.
  - usedw returns to 0 and idle=1 after tx_busy falls.
- write held high 5 cycles with data=8'h3C → exactly one push (usedw peaks at 1) and one frame sent.
- tx_busy held at 1, 17 write pulses (bytes 0..16):
  - full=1 after 16 pushes.
  - The 17th byte is dropped and overflow=1.
  - Release tx_busy: bytes 0..15 are sent in order and byte 16 never appears.
- 20 bytes pushed while draining (write and pop in the same cycles), crossing pointer wrap → output order exactly matches input order and usedw never exceeds DEPTH.
- Assert rst during WAIT_DONE with 3 bytes queued:
  - Next cycle tx_start=0, usedw=0, empty=1, overflow=0 and state is IDLE.
  - No further tx_start after release.
- write high across rst deassertion → no push. A subsequent fall-then-rise of write → exactly one push.
